vibrato_scheduler: RTL and testbench
====================================

# vibrato_scheduler

Time-multiplexes one vibrato computation across all operator slots once per sample period. Owns the shared 13-bit vibrato LFO index. Each frame it walks every slot, reads its fnum and vibrato-enable from the channel register file, computes the vibrato offset, and writes the result to the per-slot phase-increment buffer. It sits between the register file and the phase generators, replacing per-slot LFO counters.

## Interface
Parameters:
- NUM_SLOTS, 18, operator slots serviced per frame
- FNUM_WIDTH, 10, fnum / vib_val width
- SLOT_WIDTH, 5, slot index width; must satisfy 2**SLOT_WIDTH >= NUM_SLOTS

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- sample_clk_en  in  1  one-cycle pulse per sample period
- dvb  in  1  global deep-vibrato register bit
- rd_en  out  1  register-file read strobe
- rd_slot  out  SLOT_WIDTH  slot being read
- rd_fnum  in  FNUM_WIDTH  fnum of rd_slot, valid the cycle after rd_en
- rd_vib  in  1  slot vibrato enable, valid with rd_fnum
- wr_en  out  1  result write strobe
- wr_slot  out  SLOT_WIDTH  slot being written
- wr_vib_val  out  FNUM_WIDTH  vibrato offset for wr_slot
- lfo_index  out  13  current LFO index
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse with last write
- overrun  out  1  one-cycle pulse: sample_clk_en arrived while busy

## Operation
- States:
  - IDLE: waits for a frame to start.
  - RUN: issues one read per cycle.
  - DRAIN: flushes the two-stage pipeline.
- lfo_index increments by 1 on every sample_clk_en, in any state. It wraps 8191 -> 0.
- IDLE + sample_clk_en:
  - frame_index <= lfo_index+1 (the post-increment value).
  - dvb_q <= dvb.
  - slot counter <= 0; go to RUN.
- RUN:
  - rd_en=1, rd_slot=counter; counter increments.
  - After issuing slot NUM_SLOTS-1, go to DRAIN.
- DRAIN: stays until the last wr_en, then returns to IDLE.
- sample_clk_en while busy:
  - No restart. overrun pulses the next cycle.
  - The current frame completes using its latched frame_index and dvb_q.
- Computation per slot, all FNUM_WIDTH wide, using frame_index (fi):
  - d0 = rd_fnum >> 7.
  - d1 = (fi[11:10]==3) ? d0>>1 : d0.
  - d2 = dvb_q ? d1 : d1>>1.
  - val = fi[12] ? ~d2 (full width) : d2.
  - If rd_vib=0, val = 0.
- wr_slot/wr_vib_val are registered. They hold their last value when wr_en=0.
- Reset (any time, including mid-frame):
  - State -> IDLE.
  - All outputs 0: rd_en, rd_slot, wr_en, wr_slot, wr_vib_val, lfo_index, busy, frame_done, overrun.
  - Pipeline valids cleared, so no wr_en is issued for an aborted frame.
  - sample_clk_en coincident with rst is ignored.

## Timing
- sample_clk_en high in cycle T (IDLE):
  - lfo_index new value visible at T+1.
  - busy=1 from T+1.
  - rd_en with slot k at T+1+k.
- Read data arrives at T+2+k. Write for slot k at T+3+k (read-to-write latency 2).
- Last slot (17 at default) is read at T+18 and written at T+20. frame_done=1 at T+20.
- busy=1 over T+1..T+20; 0 at T+21. A new sample_clk_en at T+21 or later starts a frame normally.
- Minimum sample period without overrun: NUM_SLOTS+3 = 21 cycles.
- overrun is asserted the cycle after the offending sample_clk_en.
- rd_en and wr_en are never high for the same slot in the same cycle.

## Test plan
- Reset, pulse sample_clk_en once; all slots rd_fnum=0x3FF, rd_vib=1, dvb=1:
  - lfo_index=1.
  - wr_en for slots 0..17 on consecutive cycles starting 3 cycles after the pulse.
  - Each wr_vib_val=0x007; frame_done coincides with slot 17.
- Preload lfo_index to 0xBFF via 3071 pulses spaced 25 cycles apart; next frame (fi=0xC00), fnum=0x3FF, dvb=1 -> wr_vib_val=0x003. Same index with dvb=0 -> 0x001.
- Frame with fi=0x1000, fnum=0x3FF, dvb=1 -> 0x3F8. Same frame with rd_vib=0 on odd slots -> odd slots 0x000, even slots 0x3F8.
- Second sample_clk_en 10 cycles after the first:
  - overrun pulses once.
  - lfo_index=2.
  - Frame still writes 18 slots computed with fi=1.
  - No second frame starts.
- 8192 pulses spaced 25 cycles apart -> lfo_index returns to 0, no overrun.
- Assert rst at slot 7's read cycle, release next cycle:
  - No wr_en afterwards; all outputs 0; busy=0.
  - Next sample_clk_en produces lfo_index=1 and a full 18-slot frame.

Source files
------------

// File: rtl/vibrato_scheduler.sv
// Shared vibrato engine: walks all operator slots once per sample period and
// writes each slot's vibrato offset, owning the single 13-bit LFO index.
module vibrato_scheduler #(
  parameter int NUM_SLOTS  = 18,
  parameter int FNUM_WIDTH = 10,
  parameter int SLOT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_clk_en,
  input  logic                  dvb,
  output logic                  rd_en,
  output logic [SLOT_WIDTH-1:0] rd_slot,
  input  logic [FNUM_WIDTH-1:0] rd_fnum,
  input  logic                  rd_vib,
  output logic                  wr_en,
  output logic [SLOT_WIDTH-1:0] wr_slot,
  output logic [FNUM_WIDTH-1:0] wr_vib_val,
  output logic [12:0]           lfo_index,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun
);

  // state | meaning
  // IDLE  | waiting for sample_clk_en to start a frame
  // RUN   | one register-file read per cycle, slots 0..NUM_SLOTS-1
  // DRAIN | reads finished, flushing the read/write pipeline
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [SLOT_WIDTH-1:0] LAST_SLOT = SLOT_WIDTH'(NUM_SLOTS - 1);

  state_t                  state, state_nxt;
  logic [SLOT_WIDTH-1:0]   cnt;
  logic [12:0]             frame_index;
  logic                    dvb_q;
  logic                    p1_valid;
  logic [SLOT_WIDTH-1:0]   p1_slot;
  logic [FNUM_WIDTH-1:0]   d0, d1, d2, vib_val;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // DRAIN leaves on the registered frame_done, i.e. the cycle of the last write
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_clk_en)    state_nxt = RUN;
      RUN:     if (cnt == LAST_SLOT) state_nxt = DRAIN;
      DRAIN:   if (frame_done)       state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_en   = (state == RUN);
  assign rd_slot = rd_en ? cnt : '0;
  assign busy    = (state != IDLE);

  always_comb begin
    d0      = rd_fnum >> 7;
    d1      = (frame_index[11:10] == 2'b11) ? (d0 >> 1) : d0;
    d2      = dvb_q ? d1 : (d1 >> 1);
    vib_val = '0;
    if (rd_vib) vib_val = frame_index[12] ? ~d2 : d2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      lfo_index   <= '0;
      frame_index <= '0;
      dvb_q       <= 1'b0;
      p1_valid    <= 1'b0;
      p1_slot     <= '0;
      wr_en       <= 1'b0;
      wr_slot     <= '0;
      wr_vib_val  <= '0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (sample_clk_en) lfo_index <= lfo_index + 13'd1;
      overrun <= sample_clk_en && (state != IDLE);
      if (state == IDLE && sample_clk_en) begin
        frame_index <= lfo_index + 13'd1;
        dvb_q       <= dvb;
        cnt         <= '0;
      end else if (state == RUN) begin
        cnt <= cnt + SLOT_WIDTH'(1);
      end
      // stage 1 tracks the outstanding read; stage 2 is the registered write
      p1_valid   <= rd_en;
      p1_slot    <= rd_slot;
      wr_en      <= p1_valid;
      frame_done <= p1_valid && (p1_slot == LAST_SLOT);
      if (p1_valid) begin
        wr_slot    <= p1_slot;
        wr_vib_val <= vib_val;
      end
    end
  end

endmodule

// File: tb/tb_vibrato_scheduler.sv
// Randomized bench for vibrato_scheduler with a behavioural register file and
// an arithmetic reference model of the per-slot vibrato offset.
module tb_vibrato_scheduler;

  localparam int NS = 18;
  localparam int FW = 10;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_clk_en = 1'b0;
  logic          dvb = 1'b0;
  logic          rd_en;
  logic [SW-1:0] rd_slot;
  logic [FW-1:0] rd_fnum = '0;
  logic          rd_vib = 1'b0;
  logic          wr_en;
  logic [SW-1:0] wr_slot;
  logic [FW-1:0] wr_vib_val;
  logic [12:0]   lfo_index;
  logic          busy;
  logic          frame_done;
  logic          overrun;

  int checks = 0;
  int errors = 0;
  int model_lfo = 0;
  int ov_count = 0;
  int fnum_mem [0:31];
  bit vib_mem  [0:31];

  vibrato_scheduler #(.NUM_SLOTS(NS), .FNUM_WIDTH(FW), .SLOT_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .sample_clk_en(sample_clk_en), .dvb(dvb),
    .rd_en(rd_en), .rd_slot(rd_slot), .rd_fnum(rd_fnum), .rd_vib(rd_vib),
    .wr_en(wr_en), .wr_slot(wr_slot), .wr_vib_val(wr_vib_val),
    .lfo_index(lfo_index), .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // register file: data for the strobed slot one cycle later, garbage otherwise
  always @(posedge clk) begin
    rd_fnum <= rd_en ? FW'(fnum_mem[rd_slot]) : FW'($urandom);
    rd_vib  <= rd_en ? vib_mem[rd_slot] : 1'($urandom);
  end

  always @(negedge clk) if (overrun) ov_count++;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 2000000");
    $fatal(1);
  end

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int ref_vib(input int fnum, input bit vib, input int fi, input bit dv);
    int d;
    if (!vib) return 0;
    d = fnum / 128;
    if (((fi / 1024) % 4) == 3) d = d / 2;
    if (!dv) d = d / 2;
    if (((fi / 4096) % 2) == 1) d = ((1 << FW) - 1) - d;
    return d;
  endfunction

  task automatic check_all_zero(input string pfx);
    check({pfx, "_rd_en"}, rd_en, 0);
    check({pfx, "_rd_slot"}, rd_slot, 0);
    check({pfx, "_wr_en"}, wr_en, 0);
    check({pfx, "_wr_slot"}, wr_slot, 0);
    check({pfx, "_wr_vib_val"}, wr_vib_val, 0);
    check({pfx, "_lfo_index"}, lfo_index, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_frame_done"}, frame_done, 0);
    check({pfx, "_overrun"}, overrun, 0);
  endtask

  // sample_clk_en asserted alongside rst must not advance the LFO
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sample_clk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sample_clk_en = 1'b0;
    model_lfo = 0;
    check_all_zero("reset");
    @(negedge clk);
  endtask

  task automatic fill(input int mode);
    for (int s = 0; s < 32; s++) begin
      case (mode)
        0: begin fnum_mem[s] = 'h3FF; vib_mem[s] = 1'b1; end
        1: begin fnum_mem[s] = 'h3FF; vib_mem[s] = (s % 2 == 0); end
        default: begin fnum_mem[s] = int'($urandom_range(0, 1023)); vib_mem[s] = 1'($urandom); end
      endcase
    end
  endtask

  // Called just after a negedge with the DUT idle; pulses in this cycle (T) and
  // checks cycles T+1..T+21. ov_c > 0 adds a second pulse in cycle T+ov_c.
  task automatic do_frame(input int ov_c);
    int fi;
    bit dv;
    bit rd_x, wr_x;
    int last_val;
    dv = dvb;
    sample_clk_en = 1'b1;
    model_lfo = (model_lfo + 1) % 8192;
    fi = model_lfo;
    last_val = 0;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (ov_c > 0 && c == ov_c + 1) model_lfo = (model_lfo + 1) % 8192;
      sample_clk_en = (c == ov_c);
      dvb = 1'($urandom);
      rd_x = (c >= 1 && c <= NS);
      wr_x = (c >= 3 && c <= NS + 2);
      check("rd_en", rd_en, int'(rd_x));
      if (rd_x) check("rd_slot", rd_slot, c - 1);
      check("wr_en", wr_en, int'(wr_x));
      if (wr_x) begin
        last_val = ref_vib(fnum_mem[c - 3], vib_mem[c - 3], fi, dv);
        check("wr_slot", wr_slot, c - 3);
        check("wr_vib_val", wr_vib_val, last_val);
      end
      if (c == 21) begin
        check("wr_slot_hold", wr_slot, NS - 1);
        check("wr_vib_val_hold", wr_vib_val, last_val);
      end
      check("frame_done", frame_done, int'(c == NS + 2));
      check("busy", busy, int'(c <= NS + 2));
      check("overrun", overrun, int'(ov_c > 0 && c == ov_c + 1));
      check("lfo_index", lfo_index, model_lfo);
    end
  endtask

  // Back-to-back pulses every cycle; frames restart every 21 cycles, all
  // other pulses land while busy and each produces one overrun pulse.
  task automatic pulses(input int n);
    int ov0;
    if (n == 0) return;
    ov0 = ov_count;
    for (int i = 0; i < n; i++) begin
      sample_clk_en = 1'b1;
      @(negedge clk);
    end
    sample_clk_en = 1'b0;
    repeat (30) @(negedge clk);
    model_lfo = (model_lfo + n) % 8192;
    check("dense_overrun_count", ov_count - ov0, n - (n + 20) / 21);
    check("dense_lfo_index", lfo_index, model_lfo);
    check("dense_busy", busy, 0);
  endtask

  task automatic seek(input int target);
    pulses((target - model_lfo + 8192) % 8192);
  endtask

  task automatic random_frames(input int n);
    int ov0;
    ov0 = ov_count;
    for (int i = 0; i < n; i++) begin
      fill(2);
      dvb = 1'($urandom);
      do_frame(0);
    end
    check("spaced_no_overrun", ov_count - ov0, 0);
  endtask

  task automatic mid_reset();
    bit found;
    bit wr_seen;
    found = 1'b0;
    wr_seen = 1'b0;
    fill(2);
    sample_clk_en = 1'b1;
    @(negedge clk);
    sample_clk_en = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (rd_en && rd_slot == 7) found = 1'b1;
      else @(negedge clk);
    end
    check("mid_slot7_read_seen", int'(found), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_lfo = 0;
    check_all_zero("mid_reset");
    repeat (25) begin
      @(negedge clk);
      if (wr_en || busy) wr_seen = 1'b1;
    end
    check("mid_reset_no_activity", int'(wr_seen), 0);
    fill(0);
    dvb = 1'b1;
    do_frame(0);
  endtask

  initial begin
    fill(0);
    do_reset();

    fill(0); dvb = 1'b1; do_frame(0);
    random_frames(2);

    do_reset();
    fill(0); dvb = 1'b1; do_frame(10);
    repeat (5) begin
      @(negedge clk);
      check("no_second_frame", int'(rd_en || busy), 0);
    end
    random_frames(2);

    seek('hBFF);
    fill(0); dvb = 1'b1; do_frame(0);
    random_frames(1);
    seek('hBFF);
    fill(0); dvb = 1'b0; do_frame(0);

    seek('hFFF);
    fill(0); dvb = 1'b1; do_frame(0);
    fill(1); dvb = 1'b1; do_frame(0);
    random_frames(2);

    seek(8191);
    random_frames(20);

    mid_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
